// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: fetch PC, single-outstanding imem req/ack, prefetch FIFO to IF/ID.
// Define FETCH_PERF_CNT_EN to add the stall_cycles / empty_cycles performance counters.
module fetch_queue_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] empty_cycles
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t             state_q, state_d;
    logic [31:0]        fpc_q, fpc_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               req_q, req_d;
    logic               push, pop;

    logic [31:0]        instr_mem [DEPTH];
    logic [31:0]        pc_mem    [DEPTH];

    assign imem_req  = req_q;
    assign imem_addr = fpc_q;
    assign id_valid  = (count_q != '0);
    assign id_instr  = id_valid ? instr_mem[head_q] : 32'h0;
    assign id_pc     = id_valid ? pc_mem[head_q]    : 32'h0;

    assign push = (state_q == WAIT) && imem_ack && !redirect;
    assign pop  = id_valid && id_ready && !redirect;

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        // Redirect wins over push and pop: the whole queue is flushed on this edge.
        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fpc_d = redirect_pc;
                end else if (count_q < CNT_W'(DEPTH)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fpc_d   = redirect_pc;
                    state_d = imem_ack ? IDLE : DISCARD;
                end else if (imem_ack) begin
                    fpc_d   = fpc_q + 32'd4;
                    state_d = (count_d < CNT_W'(DEPTH)) ? WAIT : IDLE;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    fpc_d = redirect_pc;
                end
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            fpc_q   <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            req_q   <= req_d;
        end
    end

    // Entry storage needs no reset; count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail_q] <= imem_data;
            pc_mem[tail_q]    <= fpc_q + 32'd4;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] empty_q, empty_d;

    always_comb begin
        stall_d = stall_q;
        empty_d = empty_q;
        if (id_valid && !id_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
        if (!id_valid && (empty_q != 32'hFFFF_FFFF)) begin
            empty_d = empty_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            empty_q <= '0;
        end else begin
            stall_q <= stall_d;
            empty_q <= empty_d;
        end
    end

    assign stall_cycles = stall_q;
    assign empty_cycles = empty_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: variable-latency memory model plus an expected-entry scoreboard.
module tb_fetch_queue_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] empty_cycles;
`endif

    int          latency;
    int          lat_cnt;
    logic        spurious_ack;
    logic [63:0] exp_q [$];
    logic [31:0] exp_fpc;
    bit          drop_next;
    int          push_cnt;

    int          pass_cnt;
    int          chk_cnt;

    logic        s_valid;
    logic        s_req;
    logic [31:0] s_addr;
    logic [31:0] s_instr;
    logic [31:0] s_pc;

    fetch_queue_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .empty_cycles(empty_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_ack  = (imem_req && (lat_cnt >= latency)) || spurious_ack;
    assign imem_data = imem_addr ^ KEY;

    // Memory latency counter and scoreboard producer: every accepted ack pushes the expected entry.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt   <= 0;
            exp_q.delete();
            drop_next = 1'b0;
            exp_fpc   = RESET_PC;
        end else begin
            lat_cnt <= (!imem_req || imem_ack) ? 0 : lat_cnt + 1;
            if (redirect) exp_q.delete();
            if (imem_req && imem_ack) begin
                if (!redirect && !drop_next) begin
                    exp_q.push_back({exp_fpc ^ KEY, exp_fpc + 32'd4});
                    exp_fpc  = exp_fpc + 32'd4;
                    push_cnt = push_cnt + 1;
                end
                drop_next = 1'b0;
            end else if (imem_req && redirect) begin
                drop_next = 1'b1;
            end
            if (redirect) exp_fpc = redirect_pc;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] timeout");
    end

    task automatic sample();
        @(negedge clk);
        s_valid = id_valid;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_instr = id_instr;
        s_pc    = id_pc;
    endtask

    task automatic test_reset();
        logic [63:0] e;
        rst = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        latency = 0; spurious_ack = 1'b0;
        sample(); sample();
        chk_cnt++; if (s_req !== 1'b0) $display("[TB] FAIL reset_req: got %b expected 0", s_req); else pass_cnt++;
        chk_cnt++; if (s_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", s_valid); else pass_cnt++;
        chk_cnt++; if (s_instr !== 32'h0) $display("[TB] FAIL reset_instr: got %h expected 0", s_instr); else pass_cnt++;
        chk_cnt++; if (s_pc !== 32'h0) $display("[TB] FAIL reset_pc: got %h expected 0", s_pc); else pass_cnt++;
        rst = 1'b0;
        sample();
        chk_cnt++; if (s_req !== 1'b1) $display("[TB] FAIL first_req: got %b expected 1", s_req); else pass_cnt++;
        chk_cnt++; if (s_addr !== RESET_PC) $display("[TB] FAIL first_addr: got %h expected %h", s_addr, RESET_PC); else pass_cnt++;
        chk_cnt++; if (s_valid !== 1'b0) $display("[TB] FAIL cycle1_valid: got %b expected 0", s_valid); else pass_cnt++;
        sample();
        chk_cnt++; if (s_valid !== 1'b1) $display("[TB] FAIL cycle2_valid: got %b expected 1", s_valid); else pass_cnt++;
        chk_cnt++; if (s_pc !== 32'd4) $display("[TB] FAIL cycle2_pc: got %h expected 4", s_pc); else pass_cnt++;
        chk_cnt++; if (s_instr !== KEY) $display("[TB] FAIL cycle2_instr: got %h expected %h", s_instr, KEY); else pass_cnt++;
        chk_cnt++;
        if (exp_q.size() == 0) $display("[TB] FAIL reset_sb: got pc %h expected a queued entry", s_pc);
        else begin
            e = exp_q.pop_front();
            if ({s_instr, s_pc} !== e) $display("[TB] FAIL reset_sb: got %h expected %h", {s_instr, s_pc}, e); else pass_cnt++;
        end
    endtask

    task automatic test_stream();
        logic [63:0] e;
        for (int i = 0; i < 12; i++) begin
            sample();
            chk_cnt++; if (s_valid !== 1'b1) $display("[TB] FAIL stream_valid[%0d]: got %b expected 1", i, s_valid); else pass_cnt++;
            chk_cnt++; if (s_pc !== 32'd8 + 32'(4 * i)) $display("[TB] FAIL stream_pc[%0d]: got %h expected %h", i, s_pc, 32'd8 + 32'(4 * i)); else pass_cnt++;
            if (s_valid && id_ready && !redirect) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("[TB] FAIL stream_sb: got pc %h expected a queued entry", s_pc);
                else begin
                    e = exp_q.pop_front();
                    if ({s_instr, s_pc} !== e) $display("[TB] FAIL stream_sb: got %h expected %h", {s_instr, s_pc}, e); else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [63:0] e;
        int          pushes0;
        sample();
        redirect = 1'b1; redirect_pc = 32'h200; id_ready = 1'b0;
        sample();
        redirect = 1'b0;
        chk_cnt++; if (s_valid !== 1'b0) $display("[TB] FAIL stall_flush_valid: got %b expected 0", s_valid); else pass_cnt++;
        pushes0 = push_cnt;
        repeat (12) sample();
        chk_cnt++; if (push_cnt - pushes0 !== DEPTH) $display("[TB] FAIL stall_pushes: got %0d expected %0d", push_cnt - pushes0, DEPTH); else pass_cnt++;
        chk_cnt++; if (s_req !== 1'b0) $display("[TB] FAIL stall_req: got %b expected 0", s_req); else pass_cnt++;
        chk_cnt++; if (s_valid !== 1'b1) $display("[TB] FAIL stall_valid: got %b expected 1", s_valid); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) sample();
            id_ready = 1'b1;
            chk_cnt++; if (s_valid !== 1'b1) $display("[TB] FAIL drain_valid[%0d]: got %b expected 1", i, s_valid); else pass_cnt++;
            chk_cnt++; if (s_pc !== 32'h204 + 32'(4 * i)) $display("[TB] FAIL drain_pc[%0d]: got %h expected %h", i, s_pc, 32'h204 + 32'(4 * i)); else pass_cnt++;
            if (s_valid && id_ready && !redirect) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("[TB] FAIL drain_sb: got pc %h expected a queued entry", s_pc);
                else begin
                    e = exp_q.pop_front();
                    if ({s_instr, s_pc} !== e) $display("[TB] FAIL drain_sb: got %h expected %h", {s_instr, s_pc}, e); else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_redirect_wait();
        logic [63:0] e;
        logic [31:0] stale;
        bit          found;
        int          nvalid;
        latency = 3; found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (s_req && !imem_ack) begin
                found = 1'b1;
                break;
            end
            if (s_valid && id_ready && !redirect) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("[TB] FAIL rw_pre_sb: got pc %h expected a queued entry", s_pc);
                else begin
                    e = exp_q.pop_front();
                    if ({s_instr, s_pc} !== e) $display("[TB] FAIL rw_pre_sb: got %h expected %h", {s_instr, s_pc}, e); else pass_cnt++;
                end
            end
        end
        chk_cnt++; if (!found) $display("[TB] FAIL rw_wait_state: got no pending request expected one within 20 cycles"); else pass_cnt++;
        stale = s_addr ^ KEY;
        redirect = 1'b1; redirect_pc = 32'h100;
        nvalid = 0;
        for (int i = 0; i < 40 && nvalid < 4; i++) begin
            sample();
            redirect = 1'b0;
            if (i == 0) begin
                chk_cnt++; if (s_valid !== 1'b0) $display("[TB] FAIL rw_flush_valid: got %b expected 0", s_valid); else pass_cnt++;
            end
            if (s_valid) begin
                chk_cnt++; if (s_instr === stale) $display("[TB] FAIL rw_stale: got %h expected anything but the stale word", s_instr); else pass_cnt++;
                if (nvalid == 0) begin
                    chk_cnt++; if (s_pc !== 32'h104) $display("[TB] FAIL rw_first_pc: got %h expected 104", s_pc); else pass_cnt++;
                end
                nvalid++;
                chk_cnt++;
                if (exp_q.size() == 0) $display("[TB] FAIL rw_sb: got pc %h expected a queued entry", s_pc);
                else begin
                    e = exp_q.pop_front();
                    if ({s_instr, s_pc} !== e) $display("[TB] FAIL rw_sb: got %h expected %h", {s_instr, s_pc}, e); else pass_cnt++;
                end
            end
        end
        chk_cnt++; if (nvalid < 4) $display("[TB] FAIL rw_progress: got %0d entries expected 4", nvalid); else pass_cnt++;
    endtask

    task automatic test_redirect_ack_pop();
        logic [63:0] e;
        bit          found;
        latency = 0; found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (s_valid && s_req && imem_ack) begin
                found = 1'b1;
                break;
            end
            if (s_valid && id_ready && !redirect) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("[TB] FAIL rap_pre_sb: got pc %h expected a queued entry", s_pc);
                else begin
                    e = exp_q.pop_front();
                    if ({s_instr, s_pc} !== e) $display("[TB] FAIL rap_pre_sb: got %h expected %h", {s_instr, s_pc}, e); else pass_cnt++;
                end
            end
        end
        chk_cnt++; if (!found) $display("[TB] FAIL rap_setup: got no ack+pop cycle expected one within 20 cycles"); else pass_cnt++;
        redirect = 1'b1; redirect_pc = 32'h100;
        sample();
        redirect = 1'b0;
        chk_cnt++; if (s_valid !== 1'b0) $display("[TB] FAIL rap_valid: got %b expected 0", s_valid); else pass_cnt++;
        chk_cnt++; if (s_req !== 1'b0) $display("[TB] FAIL rap_idle_req: got %b expected 0", s_req); else pass_cnt++;
        sample();
        chk_cnt++; if (s_req !== 1'b1) $display("[TB] FAIL rap_req: got %b expected 1", s_req); else pass_cnt++;
        chk_cnt++; if (s_addr !== 32'h100) $display("[TB] FAIL rap_addr: got %h expected 100", s_addr); else pass_cnt++;
        sample();
        chk_cnt++; if (s_pc !== 32'h104) $display("[TB] FAIL rap_pc: got %h expected 104", s_pc); else pass_cnt++;
        chk_cnt++;
        if (exp_q.size() == 0) $display("[TB] FAIL rap_sb: got pc %h expected a queued entry", s_pc);
        else begin
            e = exp_q.pop_front();
            if ({s_instr, s_pc} !== e) $display("[TB] FAIL rap_sb: got %h expected %h", {s_instr, s_pc}, e); else pass_cnt++;
        end
    endtask

    task automatic test_reset_midway();
        logic [63:0] e;
        int          pushes0;
        bit          found;
        sample();
        redirect = 1'b1; redirect_pc = 32'h300; id_ready = 1'b0;
        sample();
        redirect = 1'b0;
        pushes0 = push_cnt;
        repeat (3) sample();
        chk_cnt++; if (push_cnt - pushes0 !== 2) $display("[TB] FAIL rm_queued: got %0d expected 2", push_cnt - pushes0); else pass_cnt++;
        chk_cnt++; if (s_req !== 1'b1) $display("[TB] FAIL rm_wait_req: got %b expected 1", s_req); else pass_cnt++;
        latency = 3;
        #2 rst = 1'b1; spurious_ack = 1'b1;
        #1;
        chk_cnt++; if (imem_req !== 1'b0) $display("[TB] FAIL rm_req: got %b expected 0", imem_req); else pass_cnt++;
        chk_cnt++; if (id_valid !== 1'b0) $display("[TB] FAIL rm_valid: got %b expected 0", id_valid); else pass_cnt++;
        chk_cnt++; if (id_instr !== 32'h0) $display("[TB] FAIL rm_instr: got %h expected 0", id_instr); else pass_cnt++;
        chk_cnt++; if (id_pc !== 32'h0) $display("[TB] FAIL rm_pc: got %h expected 0", id_pc); else pass_cnt++;
        sample();
        rst = 1'b0;
        sample();
        spurious_ack = 1'b0; latency = 0; id_ready = 1'b1;
        chk_cnt++; if (s_req !== 1'b1) $display("[TB] FAIL rm_restart_req: got %b expected 1", s_req); else pass_cnt++;
        chk_cnt++; if (s_addr !== RESET_PC) $display("[TB] FAIL rm_restart_addr: got %h expected %h", s_addr, RESET_PC); else pass_cnt++;
        chk_cnt++; if (s_valid !== 1'b0) $display("[TB] FAIL rm_spurious: got %b expected 0", s_valid); else pass_cnt++;
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            sample();
            if (s_valid) begin
                found = 1'b1;
                chk_cnt++; if (s_pc !== 32'd4) $display("[TB] FAIL rm_first_pc: got %h expected 4", s_pc); else pass_cnt++;
                chk_cnt++;
                if (exp_q.size() == 0) $display("[TB] FAIL rm_sb: got pc %h expected a queued entry", s_pc);
                else begin
                    e = exp_q.pop_front();
                    if ({s_instr, s_pc} !== e) $display("[TB] FAIL rm_sb: got %h expected %h", {s_instr, s_pc}, e); else pass_cnt++;
                end
            end
        end
        chk_cnt++; if (!found) $display("[TB] FAIL rm_progress: got no valid expected one within 5 cycles"); else pass_cnt++;
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_counters();
        logic [63:0] e;
        logic [31:0] s0;
        sample();
        s0 = stall_cycles;
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk_cnt++; if (s_valid !== 1'b1) $display("[TB] FAIL perf_valid[%0d]: got %b expected 1", i, s_valid); else pass_cnt++;
        end
        chk_cnt++; if (stall_cycles - s0 !== 32'd5) $display("[TB] FAIL perf_stall: got %0d expected 5", stall_cycles - s0); else pass_cnt++;
        id_ready = 1'b1;
        if (s_valid && id_ready && !redirect) begin
            chk_cnt++;
            if (exp_q.size() == 0) $display("[TB] FAIL perf_sb: got pc %h expected a queued entry", s_pc);
            else begin
                e = exp_q.pop_front();
                if ({s_instr, s_pc} !== e) $display("[TB] FAIL perf_sb: got %h expected %h", {s_instr, s_pc}, e); else pass_cnt++;
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; pass_cnt = 0; chk_cnt = 0; push_cnt = 0;
        latency = 0; spurious_ack = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_ack_pop();
        test_reset_midway();
`ifdef FETCH_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
